// File: rtl/stream_signature_capture_if.sv
// Bus bundle for stream_signature_capture: run control, sampled data stream
// and the signature/verdict outputs. tog_cov only exists when the optional
// toggle-coverage feature (SIG_TOGGLE_COV_EN) is compiled in.
interface stream_signature_capture_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] sig_out;
  logic [15:0]      sample_cnt;
  logic             busy;
  logic             done;
  logic             pass;
`ifdef SIG_TOGGLE_COV_EN
  logic [WIDTH-1:0] tog_cov;

  modport master (
    output start, abort, data_in,
    input  sig_out, sample_cnt, busy, done, pass, tog_cov
  );

  modport slave (
    input  start, abort, data_in,
    output sig_out, sample_cnt, busy, done, pass, tog_cov
  );
`else
  modport master (
    output start, abort, data_in,
    input  sig_out, sample_cnt, busy, done, pass
  );

  modport slave (
    input  start, abort, data_in,
    output sig_out, sample_cnt, busy, done, pass
  );
`endif
endinterface

// File: rtl/stream_signature_capture.sv
// stream_signature_capture: after start, ignores WARMUP cycles of pipeline
// fill, then folds CAPTURE_LEN consecutive data_in samples into a MISR
// signature and compares it against GOLDEN for a single pass/fail verdict.
// Optional feature macro: SIG_TOGGLE_COV_EN adds sticky per-bit toggle
// coverage of the captured samples on tog_cov.
module stream_signature_capture #(
  parameter int               WIDTH       = 32,
  parameter int               WARMUP      = 16,
  parameter int               CAPTURE_LEN = 256,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(32'h04C11DB7),
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(32'h00000000),
  parameter logic [WIDTH-1:0] GOLDEN      = WIDTH'(32'h00000000)
) (
  input  logic                      clk,
  input  logic                      rst,
  stream_signature_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d, fold;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      warm_q, warm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             warm_last;
  logic             cap_last;
  logic             start_ok;

  // Last warm-up cycle, last capture sample, and a start that will be honoured.
  assign warm_last = (warm_q == 32'(WARMUP - 1));
  assign cap_last  = (cnt_q == 16'(CAPTURE_LEN - 1));
  assign start_ok  = bus.start && !bus.abort &&
                     (state_q == S_IDLE || state_q == S_DONE);

  // One MISR step: shift left, apply feedback on the carried-out bit, mix in data.
  assign fold = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ bus.data_in;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats everything else, start only counts when idle/done.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d = (WARMUP > 0) ? S_WARMUP : S_CAPTURE;
          end
        end
        S_WARMUP: begin
          if (warm_last) begin
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cap_last) begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values; abort freezes signature and count for debug.
  always_comb begin
    sig_d  = sig_q;
    cnt_d  = cnt_q;
    warm_d = warm_q;
    pass_d = pass_q;
    busy_d = (state_d == S_WARMUP) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
    if (bus.abort) begin
      pass_d = 1'b0;
    end else if (start_ok) begin
      sig_d  = SEED;
      cnt_d  = 16'd0;
      warm_d = 32'd0;
      pass_d = 1'b0;
    end else if (state_q == S_WARMUP) begin
      warm_d = warm_q + 32'd1;
    end else if (state_q == S_CAPTURE) begin
      sig_d = fold;
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      if (cap_last) begin
        pass_d = (fold == GOLDEN);
      end
    end
  end

  // Registered outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sig_q  <= SEED;
      cnt_q  <= 16'd0;
      warm_q <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      cnt_q  <= cnt_d;
      warm_q <= warm_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign bus.sig_out    = sig_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;

`ifdef SIG_TOGGLE_COV_EN
  logic [WIDTH-1:0] tog_q, tog_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  // Sticky toggle accumulation; the first sample of a run only primes prev.
  always_comb begin
    tog_d  = tog_q;
    prev_d = prev_q;
    if (start_ok) begin
      tog_d = '0;
    end else if (!bus.abort && state_q == S_CAPTURE) begin
      if (cnt_q != 16'd0) begin
        tog_d = tog_q | (bus.data_in ^ prev_q);
      end
      prev_d = bus.data_in;
    end
  end

  // Toggle coverage registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tog_q  <= '0;
      prev_q <= '0;
    end else begin
      tog_q  <= tog_d;
      prev_q <= prev_d;
    end
  end

  assign bus.tog_cov = tog_q;
`endif

endmodule

// File: tb/tb_stream_signature_capture.sv
// Self-checking bench for stream_signature_capture. Three instances with
// different parameter sets; expected values come from a run-level model that
// folds the captured window of samples with the MISR step.
module tb_stream_signature_capture;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  // MISR step as defined by the signature rule.
  function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] d);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ d;
  endfunction

  // Signature of n all-zero samples starting from seed.
  function automatic logic [31:0] zero_sig(input logic [31:0] seed, input int n);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = fold(s, 32'h0);
    return s;
  endfunction

  localparam int          A_W    = 2;
  localparam int          A_L    = 2;
  localparam logic [31:0] A_SEED = 32'h0;
  localparam logic [31:0] A_GOLD = 32'h3;
  localparam int          B_W    = 0;
  localparam int          B_L    = 1;
  localparam logic [31:0] B_SEED = 32'h80000000;
  localparam logic [31:0] B_GOLD = 32'h0;
  localparam int          C_W    = 1;
  localparam int          C_L    = 3;
  localparam logic [31:0] C_SEED = 32'hA5A50001;
  localparam logic [31:0] C_GOLD = zero_sig(C_SEED, C_L);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  stream_signature_capture_if #(.WIDTH(32)) ia ();
  stream_signature_capture_if #(.WIDTH(32)) ib ();
  stream_signature_capture_if #(.WIDTH(32)) ic ();

  stream_signature_capture #(
    .WIDTH(32), .WARMUP(A_W), .CAPTURE_LEN(A_L),
    .POLY(POLY), .SEED(A_SEED), .GOLDEN(A_GOLD)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia));

  stream_signature_capture #(
    .WIDTH(32), .WARMUP(B_W), .CAPTURE_LEN(B_L),
    .POLY(POLY), .SEED(B_SEED), .GOLDEN(B_GOLD)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib));

  stream_signature_capture #(
    .WIDTH(32), .WARMUP(C_W), .CAPTURE_LEN(C_L),
    .POLY(POLY), .SEED(C_SEED), .GOLDEN(C_GOLD)
  ) dut_c (.clk(clk), .rst(rst), .bus(ic));

  // Advance past one rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [50:0] got;
    rst = 1'b0;
    ia.start = 1'b0; ia.abort = 1'b0; ia.data_in = 32'h0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.data_in = 32'h0;
    ic.start = 1'b0; ic.abort = 1'b0; ic.data_in = 32'h0;
    step(); step();
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {A_SEED, 16'h0, 3'b000}) begin
      fails++; $display("[TB] FAIL reset_a: got %h expected %h", got, {A_SEED, 16'h0, 3'b000});
    end
    got = {ib.sig_out, ib.sample_cnt, ib.busy, ib.done, ib.pass};
    checks++;
    if (got !== {B_SEED, 16'h0, 3'b000}) begin
      fails++; $display("[TB] FAIL reset_b: got %h expected %h", got, {B_SEED, 16'h0, 3'b000});
    end
    got = {ic.sig_out, ic.sample_cnt, ic.busy, ic.done, ic.pass};
    checks++;
    if (got !== {C_SEED, 16'h0, 3'b000}) begin
      fails++; $display("[TB] FAIL reset_c: got %h expected %h", got, {C_SEED, 16'h0, 3'b000});
    end
`ifdef SIG_TOGGLE_COV_EN
    checks++;
    if (ic.tog_cov !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_tog: got %h expected %h", ic.tog_cov, 32'h0);
    end
`endif
    rst = 1'b1;
    step();
    checks++;
    if (ia.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL idle_after_reset: got busy=%b expected 0", ia.busy);
    end
  endtask

  task automatic test_reset_priority();
    logic [50:0] got;
    ia.data_in = 32'h1;
    ia.start = 1'b1; step();
    ia.start = 1'b0;
    step(); step(); step();
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {32'h1, 16'h1, 3'b100}) begin
      fails++; $display("[TB] FAIL prio_in_capture: got %h expected %h", got, {32'h1, 16'h1, 3'b100});
    end
    rst = 1'b0; ia.start = 1'b1;
    step();
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {A_SEED, 16'h0, 3'b000}) begin
      fails++; $display("[TB] FAIL prio_reset: got %h expected %h", got, {A_SEED, 16'h0, 3'b000});
    end
    rst = 1'b1; ia.start = 1'b0;
    step();
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {A_SEED, 16'h0, 3'b000}) begin
      fails++; $display("[TB] FAIL prio_no_run: got %h expected %h", got, {A_SEED, 16'h0, 3'b000});
    end
  endtask

  task automatic test_basic_fold();
    logic [50:0] exp_tab [0:5];
    logic [50:0] got;
    exp_tab[0] = {32'd0, 16'd0, 3'b100};
    exp_tab[1] = {32'd0, 16'd0, 3'b100};
    exp_tab[2] = {32'd0, 16'd0, 3'b100};
    exp_tab[3] = {32'd1, 16'd1, 3'b100};
    exp_tab[4] = {32'd3, 16'd2, 3'b011};
    exp_tab[5] = {32'd3, 16'd2, 3'b011};
    ia.data_in = 32'h1;
    for (int e = 0; e <= 5; e++) begin
      ia.start = (e == 0);
      step();
      got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
      checks++;
      if (got !== exp_tab[e]) begin
        fails++; $display("[TB] FAIL basic_fold_edge%0d: got %h expected %h", e, got, exp_tab[e]);
      end
    end
    ia.start = 1'b0;
  endtask

  task automatic test_poly();
    logic [50:0] got;
    ib.data_in = 32'h0;
    ib.start = 1'b1; step();
    ib.start = 1'b0;
    got = {ib.sig_out, ib.sample_cnt, ib.busy, ib.done, ib.pass};
    checks++;
    if (got !== {B_SEED, 16'h0, 3'b100}) begin
      fails++; $display("[TB] FAIL poly_start: got %h expected %h", got, {B_SEED, 16'h0, 3'b100});
    end
    step();
    got = {ib.sig_out, ib.sample_cnt, ib.busy, ib.done, ib.pass};
    checks++;
    if (got !== {32'h04C11DB7, 16'h1, 3'b010}) begin
      fails++; $display("[TB] FAIL poly_fold: got %h expected %h", got, {32'h04C11DB7, 16'h1, 3'b010});
    end
  endtask

  task automatic test_abort();
    logic [50:0] got;
    ia.data_in = 32'h1;
    ia.start = 1'b1; step();
    ia.start = 1'b0; step();
    ia.abort = 1'b1; step();
    ia.abort = 1'b0;
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {32'h0, 16'h0, 3'b000}) begin
      fails++; $display("[TB] FAIL abort_warmup: got %h expected %h", got, {32'h0, 16'h0, 3'b000});
    end
    step();
    checks++;
    if (ia.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL abort_stays_idle: got busy=%b expected 0", ia.busy);
    end
    ia.start = 1'b1; step();
    ia.start = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {32'h3, 16'h2, 3'b011}) begin
      fails++; $display("[TB] FAIL abort_prep_done: got %h expected %h", got, {32'h3, 16'h2, 3'b011});
    end
    ia.abort = 1'b1; ia.start = 1'b1; step();
    ia.abort = 1'b0; ia.start = 1'b0;
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {32'h3, 16'h2, 3'b000}) begin
      fails++; $display("[TB] FAIL abort_start_done: got %h expected %h", got, {32'h3, 16'h2, 3'b000});
    end
    step();
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {32'h3, 16'h2, 3'b000}) begin
      fails++; $display("[TB] FAIL abort_no_new_run: got %h expected %h", got, {32'h3, 16'h2, 3'b000});
    end
  endtask

  task automatic test_restart();
    logic [50:0] got, exp;
    logic [31:0] d0, d1, s1, s2;
    ia.data_in = 32'h1;
    ia.start = 1'b1; step();
    ia.start = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
    checks++;
    if (got !== {32'h3, 16'h2, 3'b011}) begin
      fails++; $display("[TB] FAIL restart_first: got %h expected %h", got, {32'h3, 16'h2, 3'b011});
    end
    for (int r = 0; r < 4; r++) begin
      d0 = $urandom;
      d1 = (r % 2 == 0) ? (fold(fold(A_SEED, d0), 32'h0) ^ A_GOLD) : $urandom;
      s1 = fold(A_SEED, d0);
      s2 = fold(s1, d1);
      ia.data_in = $urandom;
      ia.start = 1'b1; step();
      ia.start = 1'b0;
      got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
      checks++;
      if (got !== {A_SEED, 16'h0, 3'b100}) begin
        fails++; $display("[TB] FAIL restart_reload: got %h expected %h", got, {A_SEED, 16'h0, 3'b100});
      end
      ia.data_in = $urandom; step();
      ia.data_in = $urandom; step();
      ia.data_in = d0; step();
      got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
      exp = {s1, 16'h1, 3'b100};
      checks++;
      if (got !== exp) begin
        fails++; $display("[TB] FAIL restart_mid: got %h expected %h", got, exp);
      end
      ia.data_in = d1; step();
      got = {ia.sig_out, ia.sample_cnt, ia.busy, ia.done, ia.pass};
      exp = {s2, 16'h2, 2'b01, (s2 == A_GOLD)};
      checks++;
      if (got !== exp) begin
        fails++; $display("[TB] FAIL restart_verdict: got %h expected %h", got, exp);
      end
    end
  endtask

`ifdef SIG_TOGGLE_COV_EN
  task automatic test_toggle_cov();
    logic [31:0] pat [1:4];
    pat[1] = 32'hFFFFFFFF; pat[2] = 32'h0; pat[3] = 32'h5; pat[4] = 32'h1;
    ic.data_in = 32'hFFFFFFFF;
    ic.start = 1'b1; step();
    ic.start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      ic.data_in = pat[e];
      step();
    end
    checks++;
    if (ic.tog_cov !== 32'h5 || ic.done !== 1'b1) begin
      fails++; $display("[TB] FAIL toggle_cov: got tog=%h done=%b expected tog=%h done=1", ic.tog_cov, ic.done, 32'h5);
    end
    ic.data_in = 32'hFFFF0000; step();
    checks++;
    if (ic.tog_cov !== 32'h5) begin
      fails++; $display("[TB] FAIL toggle_hold_done: got %h expected %h", ic.tog_cov, 32'h5);
    end
    ic.start = 1'b1; step();
    ic.start = 1'b0;
    checks++;
    if (ic.tog_cov !== 32'h0) begin
      fails++; $display("[TB] FAIL toggle_clear_start: got %h expected %h", ic.tog_cov, 32'h0);
    end
    for (int e = 1; e <= 4; e++) step();
  endtask
`endif

  task automatic test_random();
    logic [31:0] data [0:7];
    logic [31:0] es, et;
    logic [50:0] got, exp;
    int abort_edge, kk, n;
    bit zero_run, aborted, eb, ed;
    for (int run = 0; run < 40; run++) begin
      zero_run   = ($urandom_range(3) == 0);
      abort_edge = ($urandom_range(2) == 0) ? int'($urandom_range(C_W + C_L + 1, 1)) : 0;
      for (int k = 0; k < 8; k++) data[k] = zero_run ? 32'h0 : $urandom;
      ic.abort = 1'b0; ic.data_in = $urandom;
      ic.start = 1'b1; step();
      got = {ic.sig_out, ic.sample_cnt, ic.busy, ic.done, ic.pass};
      checks++;
      if (got !== {C_SEED, 16'h0, 3'b100}) begin
        fails++; $display("[TB] FAIL rand_start run%0d: got %h expected %h", run, got, {C_SEED, 16'h0, 3'b100});
      end
      for (int k = 1; k <= C_W + C_L + 2; k++) begin
        ic.start = (k <= C_W + C_L && (abort_edge == 0 || k <= abort_edge)) ? 1'($urandom_range(1)) : 1'b0;
        ic.abort = (k == abort_edge);
        ic.data_in = data[k];
        step();
        aborted = (abort_edge != 0 && k >= abort_edge);
        kk = aborted ? abort_edge - 1 : k;
        n = kk - C_W;
        if (n < 0) n = 0;
        if (n > C_L) n = C_L;
        es = C_SEED;
        et = 32'h0;
        for (int i = 1; i <= n; i++) begin
          es = fold(es, data[C_W + i]);
          if (i > 1) et = et | (data[C_W + i] ^ data[C_W + i - 1]);
        end
        eb = !aborted && (k < C_W + C_L);
        ed = !aborted && (k >= C_W + C_L);
        exp = {es, 16'(n), eb, ed, ed && (es == C_GOLD)};
        got = {ic.sig_out, ic.sample_cnt, ic.busy, ic.done, ic.pass};
        checks++;
        if (got !== exp) begin
          fails++; $display("[TB] FAIL rand_run%0d_edge%0d: got %h expected %h", run, k, got, exp);
        end
`ifdef SIG_TOGGLE_COV_EN
        checks++;
        if (ic.tog_cov !== et) begin
          fails++; $display("[TB] FAIL rand_tog_run%0d_edge%0d: got %h expected %h", run, k, ic.tog_cov, et);
        end
`else
        if (et === 32'hx) $display("[TB] unreachable");
`endif
      end
      ic.start = 1'b0;
      ic.abort = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_reset_priority();
    test_basic_fold();
    test_poly();
    test_abort();
    test_restart();
`ifdef SIG_TOGGLE_COV_EN
    test_toggle_cov();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within the time budget");
    $fatal(1, "[TB] timeout");
  end

endmodule
